encode83_arb: RTL
=================

// Module: encode83_arb
// PURPOSE
//  Sequential 8-to-3 request encoder for the CPU control unit: the inverse of the 3-to-8 decoder.
//  - Latches up to 8 request lines into sticky pending bits.
//  - Selects one pending bit and presents its 3-bit index, plus the one-hot grant, under a valid/ack handshake.
//  - Clears the serviced bit on ack.
//  - Used to turn interrupt/event lines into a vector index for the control sequencer.
// PARAMETERS
//  ACK_TIMEOUT  default 0  cycles to wait for ack in GRANT before abandoning; 0 = wait forever
//  CNT_W        default 8  timeout counter width; ACK_TIMEOUT must be < 2**CNT_W
// PORTS
//  clk      in   1  rising-edge clock, single domain
//  rst_n    in   1  synchronous, active-low reset
//  req      in   8  request lines, sampled every edge; 1 sets the matching pending bit
//  ack      in   1  consumer accepts current grant (honoured only while valid=1)
//  code     out  3  encoded index of granted request
//  grant    out  8  one-hot decode of code while valid=1; 8'h00 otherwise
//  valid    out  1  code/grant are meaningful
//  pending  out  8  current pending-bit register
//  timeout  out  1  one-cycle pulse when a grant is abandoned for lack of ack
// BEHAVIOUR
//  Reset (rst_n=0 at an edge, any state, overrides req/ack):
//   - pending=0, code=0, grant=0, valid=0, timeout=0
//   - state=IDLE, counter=0, rr pointer=7
//  Pending update each edge: pending <= (pending & ~clr) | req.
//   - clr = one-hot of code when ack is accepted, else 0.
//   - Same-bit set and clear in one edge: set wins (bit stays 1).
//  FSM, 2 states:
//   IDLE:  if pending!=0 at the edge -> GRANT
//          - code <= selected index, valid <= 1, counter <= 0
//          else stay, valid=0.
//   GRANT: ack=1 at edge -> IDLE
//          - valid <= 0, pending[code] cleared
//          else if ACK_TIMEOUT!=0 and counter==ACK_TIMEOUT-1 -> IDLE
//          - valid <= 0, timeout <= 1 for one cycle, pending bit kept for retry
//          else counter <= counter+1.
//  - code is frozen while valid=1; new requests only set pending bits.
//  Latency: req high at edge k -> pending bit 1 after k -> valid=1 after edge k+1.
//  Throughput: at least one IDLE cycle between grants (max 1 grant per 2 cycles).
//  grant is combinational from code & valid; all other outputs registered.
//  ack while valid=0 is ignored. timeout is 0 except for the pulse cycle.
// CONFIGURATION
//  ROUND_ROBIN_EN undefined: fixed priority, highest index wins (7 > 6 > ... > 0).
//  ROUND_ROBIN_EN defined:
//   - Search ascending from (ptr+1) mod 8, wrapping 7->0.
//   - ptr <= code on accepted ack only; timeout does not move ptr.
//   - Reset ptr=7, so the first search starts at bit 0.
// TESTING
//  1 Reset: hold rst_n=0 with req=8'hFF, ack=1 -> pending=0, valid=0, grant=0, timeout=0.
//  2 Single request:
//    - req=8'h20 for 1 cycle -> valid=1 two edges later, code=5, grant=8'h20.
//    - ack=1 -> valid=0, pending=0.
//  3 Priority/contention:
//    - req=8'h81 once.
//    - Fixed mode: code=7 then, after ack, code=0.
//    - ROUND_ROBIN_EN: code=0 first, then code=7.
//  4 Set-vs-clear: while granting code=3, drive ack=1 and req=8'h08 same edge -> pending[3] stays 1, re-granted code=3.
//  5 Timeout:
//    - ACK_TIMEOUT=4, req=8'h04, never ack -> valid high exactly 4 cycles, timeout pulse 1 cycle.
//    - pending=8'h04 retained, re-granted next.
//  6 Reset mid-grant: rst_n=0 while valid=1, code=6 -> next edge valid=0, pending=0; no grant after release without new req.

Source files
------------

// File: rtl/encode83_arb.sv
// Sequential 8-to-3 request encoder/arbiter: sticky pending bits, valid/ack handshake, optional ack timeout.
// Build option: define ROUND_ROBIN_EN for rotating priority; otherwise the highest index always wins.
module encode83_arb #(
   parameter int ACK_TIMEOUT = 0,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       ack,
   output logic [2:0] code,
   output logic [7:0] grant,
   output logic       valid,
   output logic [7:0] pending,
   output logic       timeout
);

   // state | meaning
   // IDLE  | no grant outstanding; picks a pending bit on the next edge
   // GRANT | code/grant presented, waiting for ack (or timeout)
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST =
      (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       pending_q, pending_d;
   logic [2:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       clr;
   logic [2:0]       sel;

`ifdef ROUND_ROBIN_EN
   logic [2:0] ptr_q, ptr_d;
   logic       found;
   logic [2:0] idx;

   // Search upward starting just past the last serviced index.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr_q + 3'(i + 1);
         if (!found && pending_q[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      sel = '0;
      for (int i = 0; i < 8; i++) begin
         if (pending_q[i]) sel = 3'(i);
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      clr       = '0;
`ifdef ROUND_ROBIN_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (|pending_q) begin
               state_d = GRANT;
               code_d  = sel;
               valid_d = 1'b1;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (ack) begin
               state_d = IDLE;
               valid_d = 1'b0;
               clr     = 8'h01 << code_q;
`ifdef ROUND_ROBIN_EN
               ptr_d   = code_q;
`endif
            end else if ((ACK_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               // Abandon the grant but keep the pending bit so it is retried.
               state_d   = IDLE;
               valid_d   = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      // A new request on the bit being cleared wins over the clear.
      pending_d = (pending_q & ~clr) | req;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
`ifdef ROUND_ROBIN_EN
         ptr_q     <= 3'd7;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
`ifdef ROUND_ROBIN_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign code    = code_q;
   assign valid   = valid_q;
   assign pending = pending_q;
   assign timeout = timeout_q;
   assign grant   = valid_q ? (8'h01 << code_q) : 8'h00;

endmodule
